// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes and FSM states.
package md_pkg;

    // Operation codes carried on the op port
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    // Sequencer states: IDLE waits for work, RUN counts down the latency
    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_div.sv
// Combinational signed/unsigned divider with truncating quotient and
// dividend-signed remainder, plus a divide-by-zero flag.
module md_div #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             signed_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             divByZero_o
);

    logic             negA;
    logic             negB;
    logic [WIDTH:0]   extA;
    logic [WIDTH:0]   extB;
    logic [WIDTH:0]   magA;
    logic [WIDTH:0]   magB;
    logic [WIDTH:0]   magQ;
    logic [WIDTH:0]   magR;

    // Divide magnitudes one bit wider than the operands so that the most-negative
    // dividend has a representable magnitude, then restore the signs; a zero
    // divisor is replaced by one to keep the arithmetic defined, and the result
    // is forced to zero since the caller discards it anyway.
    always_comb begin
        negA        = signed_i & dividend_i[WIDTH-1];
        negB        = signed_i & divisor_i[WIDTH-1];
        extA        = {negA, dividend_i};
        extB        = {negB, divisor_i};
        magA        = negA ? -extA : extA;
        magB        = negB ? -extB : extB;
        divByZero_o = (divisor_i == '0);
        if (divByZero_o) begin
            magB = {{WIDTH{1'b0}}, 1'b1};
        end
        magQ        = magA / magB;
        magR        = magA % magB;
        quotient_o  = (negA ^ negB) ? WIDTH'(-magQ) : WIDTH'(magQ);
        remainder_o = negA ? WIDTH'(-magR) : WIDTH'(magR);
        if (divByZero_o) begin
            quotient_o  = '0;
            remainder_o = '0;
        end
    end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers. Results are computed when an
// operation is accepted, held privately, and committed to HI/LO only when the
// latency counter expires, so HI/LO keep their old values while busy.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   resultHi_q, resultHi_d;
    logic [WIDTH-1:0]   resultLo_q, resultLo_d;
    logic               writeBack_q, writeBack_d;

    logic               canAccept;
    logic [2*WIDTH-1:0] mulA;
    logic [2*WIDTH-1:0] mulB;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic               divByZero;

    // Full-width product: sign- or zero-extend to 2*WIDTH so the low 2*WIDTH
    // bits of the product are exact for both MULT and MULTU.
    always_comb begin
        mulA    = (op == MD_MULT) ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        mulB    = (op == MD_MULT) ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        product = mulA * mulB;
    end

    md_div #(
        .WIDTH (WIDTH)
    ) u_div (
        .dividend_i  (a),
        .divisor_i   (b),
        .signed_i    (op == MD_DIV),
        .quotient_o  (quotient),
        .remainder_o (remainder),
        .divByZero_o (divByZero)
    );

    // Next-state logic: count down and commit in RUN, then take a new
    // operation when idle or on the completing edge itself, so back-to-back
    // work loses no cycle; a new MTHI/MTLO on that edge overrides the commit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        resultHi_d  = resultHi_q;
        resultLo_d  = resultLo_q;
        writeBack_d = writeBack_q;
        canAccept   = 1'b0;

        if (state_q == MD_RUN) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d   = MD_IDLE;
                canAccept = 1'b1;
                if (writeBack_q) begin
                    hi_d = resultHi_q;
                    lo_d = resultLo_q;
                end
            end
        end else begin
            canAccept = 1'b1;
        end

        if (start && canAccept) begin
            case (op)
                MD_MULT, MD_MULTU: begin
                    state_d     = MD_RUN;
                    cnt_d       = CNT_W'(MULT_CYCLES);
                    resultHi_d  = product[2*WIDTH-1:WIDTH];
                    resultLo_d  = product[WIDTH-1:0];
                    writeBack_d = 1'b1;
                end
                MD_DIV, MD_DIVU: begin
                    state_d     = MD_RUN;
                    cnt_d       = CNT_W'(DIV_CYCLES);
                    resultHi_d  = remainder;
                    resultLo_d  = quotient;
                    writeBack_d = ~divByZero;
                end
                MD_MTHI: begin
                    hi_d = a;
                end
                MD_MTLO: begin
                    lo_d = a;
                end
                default: begin
                end
            endcase
        end
    end

    // State, counter and HI/LO registers; reset drops any in-flight result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= MD_IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            resultHi_q  <= '0;
            resultLo_q  <= '0;
            writeBack_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            resultHi_q  <= resultHi_d;
            resultLo_q  <= resultLo_d;
            writeBack_q <= writeBack_d;
        end
    end

    assign busy = (state_q == MD_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
